// File: rtl/key_calc_ctrl.sv
`timescale 1ns/1ps
// key_calc_ctrl: keypad-driven four-digit add/subtract calculator controller.
// Accepts decoded key strobes, accumulates two operands, evaluates A+B or A-B
// on equals and flags results outside +/-9999 as an overflow error.
//
// Ports:
//   clk_i           system clock, all state changes on rising edge
//   rst_ni          synchronous reset, active-low
//   key_i[3:0]      key code: 0-9 digit, 10 minus, 11 plus, 12 equals, 13 escape
//   key_valid_i     one-cycle strobe qualifying key_i
//   value_o[14:0]   signed display value (A, B, R or 0 depending on state)
//   op_o[1:0]       pending operator: 0 none, 1 plus, 2 minus
//   err_o           overflow error flag
//   result_valid_o  one-cycle pulse when a result is registered
//   state_o[1:0]    current state: 0 S_A, 1 S_B, 2 S_RES, 3 S_ERR
module key_calc_ctrl (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [3:0]  key_i,
   input  logic        key_valid_i,
   output logic [14:0] value_o,
   output logic [1:0]  op_o,
   output logic        err_o,
   output logic        result_valid_o,
   output logic [1:0]  state_o
);

   localparam int unsigned KEY_W = 4;
   localparam int unsigned VAL_W = 15;
   localparam int unsigned SUM_W = 16;
   localparam int unsigned CNT_W = 3;
   localparam int unsigned OP_W  = 2;

   localparam logic [KEY_W-1:0] KEY_DIGIT_MAX = 4'd9;
   localparam logic [KEY_W-1:0] KEY_MINUS     = 4'd10;
   localparam logic [KEY_W-1:0] KEY_PLUS      = 4'd11;
   localparam logic [KEY_W-1:0] KEY_EQUALS    = 4'd12;
   localparam logic [KEY_W-1:0] KEY_ESC       = 4'd13;

   localparam logic [OP_W-1:0]  OP_NONE  = 2'd0;
   localparam logic [OP_W-1:0]  OP_PLUS  = 2'd1;
   localparam logic [OP_W-1:0]  OP_MINUS = 2'd2;

   localparam logic [CNT_W-1:0] MAX_DIGITS = 3'd4;

   localparam logic signed [SUM_W-1:0] POS_LIMIT = 16'sd9999;
   localparam logic signed [SUM_W-1:0] NEG_LIMIT = -16'sd9999;
   localparam logic signed [VAL_W-1:0] TEN       = 15'sd10;

   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_B   = 2'd1,
      S_RES = 2'd2,
      S_ERR = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic signed [VAL_W-1:0]  a_q, a_d;
   logic signed [VAL_W-1:0]  b_q, b_d;
   logic signed [VAL_W-1:0]  r_q, r_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [OP_W-1:0]          op_q, op_d;
   logic                     err_q, err_d;
   logic                     rv_q, rv_d;
   logic [VAL_W-1:0]         value_q, value_d;
   logic [OP_W-1:0]          op_out_q, op_out_d;

   // Key decode
   logic                     is_digit;
   logic                     is_opkey;
   logic [OP_W-1:0]          key_op;
   logic signed [VAL_W-1:0]  digit_val;

   assign is_digit  = (key_i <= KEY_DIGIT_MAX);
   assign is_opkey  = (key_i == KEY_MINUS) || (key_i == KEY_PLUS);
   assign key_op    = (key_i == KEY_PLUS) ? OP_PLUS : OP_MINUS;
   assign digit_val = $signed(VAL_W'(key_i));

   // Digit accumulation; operands under entry are never negative and the
   // four-digit cap keeps them within 9999, so 15 bits cannot wrap here.
   logic signed [VAL_W-1:0]  a_entry;
   logic signed [VAL_W-1:0]  b_entry;
   logic                     can_enter;

   assign a_entry   = a_q * TEN + digit_val;
   assign b_entry   = b_q * TEN + digit_val;
   assign can_enter = (cnt_q < MAX_DIGITS);

   // Evaluation in 16 bits so +/-19998 is range-checked without wrap-around
   logic signed [SUM_W-1:0]  a_ext;
   logic signed [SUM_W-1:0]  b_ext;
   logic signed [SUM_W-1:0]  sum;
   logic                     overflow;

   assign a_ext    = {a_q[VAL_W-1], a_q};
   assign b_ext    = {b_q[VAL_W-1], b_q};
   assign sum      = (op_q == OP_MINUS) ? (a_ext - b_ext) : (a_ext + b_ext);
   assign overflow = (sum > POS_LIMIT) || (sum < NEG_LIMIT);

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      r_d      = r_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      err_d    = err_q;
      rv_d     = 1'b0;
      value_d  = '0;
      op_out_d = OP_NONE;

      if (key_valid_i) begin
         if (key_i == KEY_ESC) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            r_d     = '0;
            cnt_d   = '0;
            op_d    = OP_NONE;
            err_d   = 1'b0;
         end else begin
            case (state_q)
               S_A: begin
                  if (is_digit) begin
                     if (can_enter) begin
                        a_d   = a_entry;
                        cnt_d = cnt_q + 3'd1;
                     end
                  end else if (is_opkey) begin
                     op_d    = key_op;
                     b_d     = '0;
                     cnt_d   = '0;
                     state_d = S_B;
                  end
               end
               S_B: begin
                  if (is_digit) begin
                     if (can_enter) begin
                        b_d   = b_entry;
                        cnt_d = cnt_q + 3'd1;
                     end
                  end else if (is_opkey) begin
                     // Operator may only be changed before any B digit
                     if (cnt_q == '0) begin
                        op_d = key_op;
                     end
                  end else if (key_i == KEY_EQUALS) begin
                     r_d  = VAL_W'(sum);
                     rv_d = 1'b1;
                     if (overflow) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                     end else begin
                        state_d = S_RES;
                     end
                  end
               end
               S_RES: begin
                  if (is_digit) begin
                     a_d     = digit_val;
                     cnt_d   = 3'd1;
                     op_d    = OP_NONE;
                     state_d = S_A;
                  end else if (is_opkey) begin
                     // Chain: the result becomes the new left operand
                     a_d     = r_q;
                     b_d     = '0;
                     cnt_d   = '0;
                     op_d    = key_op;
                     state_d = S_B;
                  end
               end
               default: begin
               end
            endcase
         end
      end

      // Display selection follows the state being entered
      case (state_d)
         S_A: begin
            value_d = a_d;
         end
         S_B: begin
            value_d  = b_d;
            op_out_d = op_d;
         end
         S_RES: begin
            value_d  = r_d;
            op_out_d = op_d;
         end
         default: begin
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= S_A;
         a_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
         cnt_q    <= '0;
         op_q     <= OP_NONE;
         err_q    <= 1'b0;
         rv_q     <= 1'b0;
         value_q  <= '0;
         op_out_q <= OP_NONE;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         r_q      <= r_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         err_q    <= err_d;
         rv_q     <= rv_d;
         value_q  <= value_d;
         op_out_q <= op_out_d;
      end
   end

   assign value_o        = value_q;
   assign op_o           = op_out_q;
   assign err_o          = err_q;
   assign result_valid_o = rv_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_key_calc_ctrl.sv
`timescale 1ns/1ps
// tb_key_calc_ctrl: scoreboard bench for key_calc_ctrl. Each key strobe or
// reset cycle pushes the expected post-edge outputs from a calculator model;
// a monitor pops and compares after every such edge.
module tb_key_calc_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [3:0]  key_i;
   logic        key_valid_i;
   logic [14:0] value_o;
   logic [1:0]  op_o;
   logic        err_o;
   logic        result_valid_o;
   logic [1:0]  state_o;

   key_calc_ctrl dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .key_i          (key_i),
      .key_valid_i    (key_valid_i),
      .value_o        (value_o),
      .op_o           (op_o),
      .err_o          (err_o),
      .result_valid_o (result_valid_o),
      .state_o        (state_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int value;
      int op;
      int err;
      int rv;
      int st;
   } snap_t;

   snap_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   // Calculator model: integers, state numbered as on state_o
   int m_a, m_b, m_r, m_cnt, m_op, m_err, m_st;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d at %0t",
                  name, $signed(act), act, $signed(exp), $time);
      end
   endfunction

   function automatic logic [31:0] sval();
      return {{17{value_o[14]}}, value_o};
   endfunction

   function automatic void model_reset();
      m_a = 0; m_b = 0; m_r = 0; m_cnt = 0; m_op = 0; m_err = 0; m_st = 0;
   endfunction

   function automatic void model_push(int rv);
      snap_t s;
      s.rv  = rv;
      s.st  = m_st;
      s.err = m_err;
      s.op  = (m_st == 1 || m_st == 2) ? m_op : 0;
      case (m_st)
         0:       s.value = m_a;
         1:       s.value = m_b;
         2:       s.value = m_r;
         default: s.value = 0;
      endcase
      exp_q.push_back(s);
   endfunction

   function automatic void model_key(int k);
      int rv = 0;
      int res;
      int kop;
      kop = (k == 11) ? 1 : 2;
      if (k == 13) begin
         model_reset();
      end else if (k <= 12) begin
         case (m_st)
            0: begin
               if (k <= 9) begin
                  if (m_cnt < 4) begin m_a = m_a * 10 + k; m_cnt++; end
               end else if (k != 12) begin
                  m_op = kop; m_b = 0; m_cnt = 0; m_st = 1;
               end
            end
            1: begin
               if (k <= 9) begin
                  if (m_cnt < 4) begin m_b = m_b * 10 + k; m_cnt++; end
               end else if (k == 12) begin
                  res = (m_op == 1) ? m_a + m_b : m_a - m_b;
                  m_r = res;
                  rv  = 1;
                  if (res > 9999 || res < -9999) begin m_err = 1; m_st = 3; end
                  else m_st = 2;
               end else if (m_cnt == 0) begin
                  m_op = kop;
               end
            end
            2: begin
               if (k <= 9) begin
                  m_a = k; m_cnt = 1; m_op = 0; m_st = 0;
               end else if (k != 12) begin
                  m_a = m_r; m_b = 0; m_cnt = 0; m_op = kop; m_st = 1;
               end
            end
            default: begin
            end
         endcase
      end
      model_push(rv);
   endfunction

   // Driver tasks: inputs change on the falling edge
   task automatic send(int k);
      @(negedge clk_i);
      key_i       = 4'(k);
      key_valid_i = 1'b1;
      model_key(k);
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk_i);
         key_valid_i = 1'b0;
         key_i       = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic press(int k);
      send(k);
      idle(1);
   endtask

   task automatic do_reset(bit with_key, int k);
      @(negedge clk_i);
      rst_ni      = 1'b0;
      key_valid_i = with_key;
      key_i       = 4'(k);
      model_reset();
      model_push(0);
      @(negedge clk_i);
      rst_ni      = 1'b1;
      key_valid_i = 1'b0;
   endtask

   // Monitor: every edge with a strobe or reset consumes one expectation
   initial begin
      snap_t e;
      logic  ev;
      forever begin
         @(posedge clk_i);
         ev = key_valid_i || !rst_ni;
         #1;
         if (ev) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL scoreboard_underflow: got an event, expected queue entry at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("value_o",        sval(),                  32'(e.value));
               chk("op_o",           32'(op_o),               32'(e.op));
               chk("err_o",          32'(err_o),              32'(e.err));
               chk("result_valid_o", 32'(result_valid_o),     32'(e.rv));
               chk("state_o",        32'(state_o),            32'(e.st));
            end
         end else begin
            chk("idle_result_valid", 32'(result_valid_o), 32'd0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

   int key_tbl [20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9,
                        10, 11, 12, 10, 11, 12, 12, 13, 14, 15};

   initial begin
      int k;
      rst_ni      = 1'b0;
      key_valid_i = 1'b0;
      key_i       = 4'd0;
      model_reset();
      model_push(0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle(1);

      // Basic addition: 12 + 30
      press(1); press(2); press(11); press(3); press(0); press(12);
      chk("add_value", sval(), 32'd42);
      chk("add_state", 32'(state_o), 32'd2);
      press(13);

      // Negative result, then chaining from it
      press(5); press(10); press(8); press(12);
      chk("neg_value", sval(), -32'sd3);
      chk("neg_state", 32'(state_o), 32'd2);
      press(11); press(4); press(12);
      chk("chain_value", sval(), 32'd1);
      press(13);

      // Digit cap, overflow, ignored digit, escape
      press(1); press(2); press(3); press(4); press(5);
      chk("cap_value", sval(), 32'd1234);
      press(11); press(9); press(9); press(9); press(9); press(12);
      chk("ovf_err", 32'(err_o), 32'd1);
      chk("ovf_state", 32'(state_o), 32'd3);
      chk("ovf_value", sval(), 32'd0);
      press(7);
      chk("err_hold", 32'(err_o), 32'd1);
      press(13);
      chk("esc_state", 32'(state_o), 32'd0);
      chk("esc_err", 32'(err_o), 32'd0);

      // Back-to-back strobes with operator replacement
      send(6); send(11); send(10); send(2); send(12); idle(1);
      chk("b2b_op", 32'(op_o), 32'd2);
      chk("b2b_value", sval(), 32'd4);

      // Reset wins over a simultaneous equals
      press(9); press(11); press(3);
      do_reset(1'b1, 12);
      chk("rst_value", sval(), 32'd0);
      chk("rst_state", 32'(state_o), 32'd0);
      idle(2);

      // Unused codes in every state, equals in S_A
      press(3); press(14); press(15); press(12);
      press(11); press(14); press(15); press(11);
      press(2); press(14); press(15); press(10); press(12);
      press(14); press(15); press(12);
      press(13);
      press(9); press(9); press(9); press(9); press(11);
      press(9); press(9); press(9); press(9); press(9); press(12);
      press(14); press(15); press(12); press(11); press(3);
      press(13);

      // Negative-limit boundary: -9999 - 9999 via chained result
      press(0); press(10); press(9); press(9); press(9); press(9); press(12);
      chk("negmax_value", sval(), -32'sd9999);
      press(10); press(9); press(9); press(9); press(9); press(12);
      chk("negovf_state", 32'(state_o), 32'd3);
      press(13);

      // Randomized key stream
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
         end else begin
            k = key_tbl[$urandom_range(0, 19)];
            if ($urandom_range(0, 2) == 0) send(k);
            else press(k);
         end
      end

      idle(3);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
